// File: rtl/ix_scoreboard_pkg.sv
// ============================================================================
//  Module      : ix_scoreboard_pkg
//  Description : Shared constants, types and field helpers for the issue-stage
//                register scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// k-th register-index field of a packed vector of 5-bit indices
`define IX_FIELD(vec, k) vec[(k)*REG_IDX_W +: REG_IDX_W]

package ix_scoreboard_pkg;

    localparam int NREG_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Width needed to hold a count in the range 0..n
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ix_sb_popcnt.sv
// ============================================================================
//  Module      : ix_sb_popcnt
//  Description : Counts how many writeback ports retire a write to one
//                specific architectural register this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ix_sb_popcnt
    import ix_scoreboard_pkg::*;
#(
    parameter int NWB    = 2,
    parameter int REG_ID = 1,
    parameter int OUT_W  = 2
) (
    input  logic [NWB-1:0]           wb_valid,
    input  logic [NWB*REG_IDX_W-1:0] wb_dst,
    output logic [OUT_W-1:0]         match_cnt
);

    localparam reg_idx_t c_reg_id = REG_IDX_W'(REG_ID);

    always_comb begin
        match_cnt = '0;
        for (int k = 0; k < NWB; k++) begin
            if (wb_valid[k] && (`IX_FIELD(wb_dst, k) == c_reg_id)) begin
                match_cnt = match_cnt + OUT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ix_scoreboard.sv
// ============================================================================
//  Module      : ix_scoreboard
//  Description : Per-register pending-write counters for the issue stage with
//                source-busy queries, issue back-pressure and idle/barrier flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ix_scoreboard
    import ix_scoreboard_pkg::*;
#(
    parameter int NREG      = NREG_DEFAULT,
    parameter int NRS       = 2,
    parameter int NWB       = 2,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic                     iss_wb_en,
    input  logic [REG_IDX_W-1:0]     iss_rd,
    output logic                     iss_block,
    input  logic [NWB-1:0]           wb_valid,
    input  logic [NWB*REG_IDX_W-1:0] wb_dst,
    input  logic [NRS*REG_IDX_W-1:0] rs_idx,
    output logic [NRS-1:0]           rs_busy,
    output logic                     sb_idle,
    output logic                     sb_err
);

    localparam int               c_dec_w   = count_width(NWB);
    localparam int               c_sum_w   = CNT_W + c_dec_w;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0]   r_cnt    [NREG];
    logic [CNT_W-1:0]   w_next   [NREG];
    logic [c_dec_w-1:0] w_dec    [NREG];
    logic [NREG-1:0]    w_uflow;
    logic [CNT_W-1:0]   w_iss_cnt;
    logic               w_iss_block;
    logic               w_next_zero;
    logic               r_idle;
    logic               r_err;

    // Saturation check uses the current count only; crediting same-cycle
    // retires here would close a combinational path from wb into issue.
    always_comb begin
        w_iss_cnt = '0;
        for (int r = 0; r < NREG; r++) begin
            if (iss_rd == REG_IDX_W'(r)) begin
                w_iss_cnt = r_cnt[r];
            end
        end
    end

    assign w_iss_block = iss_valid && iss_wb_en && (iss_rd != '0) &&
                         (w_iss_cnt == c_cnt_max);
    assign iss_block   = w_iss_block;

    // x0 is never tracked
    assign w_dec[0]   = '0;
    assign w_next[0]  = '0;
    assign w_uflow[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic               w_inc;
            logic [c_sum_w-1:0] w_avail;

            ix_sb_popcnt #(
                .NWB    (NWB),
                .REG_ID (gi),
                .OUT_W  (c_dec_w)
            ) u_popcnt (
                .wb_valid  (wb_valid),
                .wb_dst    (wb_dst),
                .match_cnt (w_dec[gi])
            );

            assign w_inc       = iss_valid && iss_wb_en && !w_iss_block &&
                                 (iss_rd == REG_IDX_W'(gi));
            assign w_avail     = c_sum_w'(r_cnt[gi]) + c_sum_w'(w_inc);
            assign w_uflow[gi] = c_sum_w'(w_dec[gi]) > w_avail;
            assign w_next[gi]  = w_uflow[gi] ? '0
                                 : CNT_W'(w_avail - c_sum_w'(w_dec[gi]));
        end
    endgenerate

    generate
        for (genvar gk = 0; gk < NRS; gk++) begin : g_rs
            logic [REG_IDX_W-1:0] w_q_idx;
            logic [CNT_W-1:0]     w_q_cnt;
            logic [c_dec_w-1:0]   w_q_dec;
            logic                 w_q_retiring;

            assign w_q_idx = `IX_FIELD(rs_idx, gk);

            always_comb begin
                w_q_cnt = '0;
                w_q_dec = '0;
                for (int r = 0; r < NREG; r++) begin
                    if (w_q_idx == REG_IDX_W'(r)) begin
                        w_q_cnt = r_cnt[r];
                        w_q_dec = w_dec[r];
                    end
                end
            end

            // Last pending write retiring now: data is forwarded from the wb bus
            assign w_q_retiring = (WB_BYPASS != 0) &&
                                  (c_sum_w'(w_q_dec) >= c_sum_w'(w_q_cnt));
            assign rs_busy[gk]  = (w_q_idx != '0) && (w_q_cnt != '0) &&
                                  !w_q_retiring;
        end
    endgenerate

    always_comb begin
        w_next_zero = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (w_next[r] != '0) begin
                w_next_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_idle <= 1'b1;
            r_err  <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_next[r];
            end
            r_idle <= w_next_zero;
            r_err  <= r_err || (|w_uflow) || w_iss_block;
        end
    end

    assign sb_idle = r_idle;
    assign sb_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ix_scoreboard.sv
// ============================================================================
//  Module      : tb_ix_scoreboard
//  Description : Directed-vector scoreboard bench for ix_scoreboard, driving a
//                bypass and a non-bypass instance with identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ix_scoreboard;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic        iss_wb_en;
    logic [4:0]  iss_rd;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_dst;
    logic [9:0]  rs_idx;
    logic        iss_block, iss_block_nb;
    logic [1:0]  rs_busy, rs_busy_nb;
    logic        sb_idle, sb_idle_nb;
    logic        sb_err, sb_err_nb;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         id;
        logic [1:0] busy;
        logic [1:0] busy_nb;
        logic       block;
        logic       idle;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    ix_scoreboard #(
        .NREG(32), .NRS(2), .NWB(2), .CNT_W(2), .WB_BYPASS(1)
    ) u_dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wb_en(iss_wb_en),
        .iss_rd(iss_rd), .iss_block(iss_block), .wb_valid(wb_valid),
        .wb_dst(wb_dst), .rs_idx(rs_idx), .rs_busy(rs_busy),
        .sb_idle(sb_idle), .sb_err(sb_err)
    );

    ix_scoreboard #(
        .NREG(32), .NRS(2), .NWB(2), .CNT_W(2), .WB_BYPASS(0)
    ) u_dut_nb (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wb_en(iss_wb_en),
        .iss_rd(iss_rd), .iss_block(iss_block_nb), .wb_valid(wb_valid),
        .wb_dst(wb_dst), .rs_idx(rs_idx), .rs_busy(rs_busy_nb),
        .sb_idle(sb_idle_nb), .sb_err(sb_err_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one cycle of stimulus and queues the outputs expected mid-cycle
    task automatic step(input int id, input logic r, input logic iv, input logic iwb,
                        input logic [4:0] ird, input logic [1:0] wbv,
                        input logic [4:0] d0, input logic [4:0] d1,
                        input logic [4:0] q0, input logic [4:0] q1,
                        input logic [1:0] e_busy, input logic [1:0] e_busy_nb,
                        input logic e_block, input logic e_idle, input logic e_err);
        exp_t e;
        rst       = r;
        iss_valid = iv;
        iss_wb_en = iwb;
        iss_rd    = ird;
        wb_valid  = wbv;
        wb_dst    = {d1, d0};
        rs_idx    = {q1, q0};
        e.id = id; e.busy = e_busy; e.busy_nb = e_busy_nb;
        e.block = e_block; e.idle = e_idle; e.err = e_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int id, input string name, input logic [1:0] act,
                       input logic [1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %b expected %b", id, name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.id, "rs_busy",      rs_busy,             e.busy);
                chk(e.id, "rs_busy_nb",   rs_busy_nb,          e.busy_nb);
                chk(e.id, "iss_block",    {1'b0, iss_block},   {1'b0, e.block});
                chk(e.id, "iss_block_nb", {1'b0, iss_block_nb},{1'b0, e.block});
                chk(e.id, "sb_idle",      {1'b0, sb_idle},     {1'b0, e.idle});
                chk(e.id, "sb_idle_nb",   {1'b0, sb_idle_nb},  {1'b0, e.idle});
                chk(e.id, "sb_err",       {1'b0, sb_err},      {1'b0, e.err});
                chk(e.id, "sb_err_nb",    {1'b0, sb_err_nb},   {1'b0, e.err});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        rst = 1'b1; iss_valid = 1'b0; iss_wb_en = 1'b0; iss_rd = '0;
        wb_valid = '0; wb_dst = '0; rs_idx = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        //     id rst iv wb rd  wbv  d0  d1  q0  q1  busy  bnb  blk idl err
        // reset then idle
        step( 0, 0, 0, 0,  0, 2'b00, 0,  0,  5, 31, 2'b00, 2'b00, 0, 1, 0);
        // single hazard on x5
        step( 1, 0, 1, 1,  5, 2'b00, 0,  0,  5, 31, 2'b00, 2'b00, 0, 1, 0);
        step( 2, 0, 0, 0,  0, 2'b00, 0,  0,  5, 31, 2'b01, 2'b01, 0, 0, 0);
        step( 3, 0, 0, 0,  0, 2'b01, 5,  0,  5, 31, 2'b00, 2'b01, 0, 0, 0);
        step( 4, 0, 0, 0,  0, 2'b00, 0,  0,  5, 31, 2'b00, 2'b00, 0, 1, 0);
        // fill x7 to saturation, then a blocked 4th issue
        step( 5, 0, 1, 1,  7, 2'b00, 0,  0,  7, 31, 2'b00, 2'b00, 0, 1, 0);
        step( 6, 0, 1, 1,  7, 2'b00, 0,  0,  7, 31, 2'b01, 2'b01, 0, 0, 0);
        step( 7, 0, 1, 1,  7, 2'b00, 0,  0,  7, 31, 2'b01, 2'b01, 0, 0, 0);
        step( 8, 0, 1, 1,  7, 2'b00, 0,  0,  7, 31, 2'b01, 2'b01, 1, 0, 0);
        step( 9, 0, 0, 0,  0, 2'b00, 0,  0,  7, 31, 2'b01, 2'b01, 0, 0, 1);
        // two retires in one cycle: 3 -> 1, still busy
        step(10, 0, 0, 0,  0, 2'b11, 7,  7,  7, 31, 2'b01, 2'b01, 0, 0, 1);
        step(11, 0, 0, 0,  0, 2'b00, 0,  0,  7, 31, 2'b01, 2'b01, 0, 0, 1);
        step(12, 1, 0, 0,  0, 2'b00, 0,  0,  7, 31, 2'b01, 2'b01, 0, 0, 1);
        step(13, 0, 0, 0,  0, 2'b00, 0,  0,  7, 31, 2'b00, 2'b00, 0, 1, 0);
        // simultaneous issue and retire on x3
        step(14, 0, 1, 1,  3, 2'b00, 0,  0,  3, 31, 2'b00, 2'b00, 0, 1, 0);
        step(15, 0, 1, 1,  3, 2'b01, 3,  0,  3, 31, 2'b00, 2'b01, 0, 0, 0);
        step(16, 0, 0, 0,  0, 2'b00, 0,  0,  3, 31, 2'b01, 2'b01, 0, 0, 0);
        step(17, 0, 0, 0,  0, 2'b01, 3,  0,  3, 31, 2'b00, 2'b01, 0, 0, 0);
        // x0 is never tracked
        step(18, 0, 1, 1,  0, 2'b11, 0,  0,  0,  3, 2'b00, 2'b00, 0, 1, 0);
        step(19, 0, 1, 1,  0, 2'b11, 0,  0,  0,  3, 2'b00, 2'b00, 0, 1, 0);
        step(20, 0, 1, 1,  0, 2'b00, 0,  0,  0,  0, 2'b00, 2'b00, 0, 1, 0);
        // underflow on x9
        step(21, 0, 0, 0,  0, 2'b01, 9,  0,  9, 31, 2'b00, 2'b00, 0, 1, 0);
        step(22, 0, 0, 0,  0, 2'b00, 0,  0,  9, 31, 2'b00, 2'b00, 0, 1, 1);
        step(23, 1, 0, 0,  0, 2'b00, 0,  0,  9, 31, 2'b00, 2'b00, 0, 1, 1);
        // reset mid-operation with x4 holding two writes
        step(24, 0, 1, 1,  4, 2'b00, 0,  0,  4, 31, 2'b00, 2'b00, 0, 1, 0);
        step(25, 0, 1, 1,  4, 2'b00, 0,  0,  4, 31, 2'b01, 2'b01, 0, 0, 0);
        step(26, 1, 1, 1,  4, 2'b00, 0,  0,  4, 31, 2'b01, 2'b01, 0, 0, 0);
        step(27, 0, 0, 0,  0, 2'b00, 0,  0,  4,  4, 2'b00, 2'b00, 0, 1, 0);
        // retire through port 1 only
        step(28, 0, 1, 1, 12, 2'b00, 0,  0, 12, 12, 2'b00, 2'b00, 0, 1, 0);
        step(29, 0, 0, 0,  0, 2'b10, 0, 12, 12, 12, 2'b00, 2'b11, 0, 0, 0);
        step(30, 0, 0, 0,  0, 2'b00, 0,  0, 12, 12, 2'b00, 2'b00, 0, 1, 0);
        // issue without a destination write
        step(31, 0, 1, 0,  6, 2'b00, 0,  0,  6, 31, 2'b00, 2'b00, 0, 1, 0);
        step(32, 0, 0, 0,  0, 2'b00, 0,  0,  6, 31, 2'b00, 2'b00, 0, 1, 0);

        iss_valid = 1'b0; wb_valid = '0;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
